// File: rtl/jtdsp16_seq.sv
// jtdsp16_seq: JTDSP16 program sequencer with return stack, interrupts and zero-overhead do loop; define JTDSP16_SEQ_ERR_EN for sticky error flags
module jtdsp16_seq #(
  parameter int AW        = 16,
  parameter int SDEPTH    = 4,
  parameter int CW        = 7,
  parameter int NW        = 4,
  parameter int IRQ_VEC   = 1,
  parameter int ICALL_VEC = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cen,
  input  logic                      goto_ja,
  input  logic                      goto_pt,
  input  logic                      call_ja,
  input  logic                      call_pt,
  input  logic                      ret,
  input  logic                      iret,
  input  logic                      icall,
  input  logic                      ext_irq,
  input  logic                      shadow,
  input  logic                      post_inc,
  input  logic                      pt_load,
  input  logic [AW-1:0]             pt_din,
  input  logic                      do_start,
  input  logic [NW-1:0]             do_len,
  input  logic [CW-1:0]             do_cnt,
  input  logic [11:0]               i_field,
`ifdef JTDSP16_SEQ_ERR_EN
  output logic                      stk_ovf,
  output logic                      stk_unf,
  output logic                      loop_abort,
`endif
  output logic [AW-1:0]             rom_addr,
  output logic [AW-1:0]             pt,
  output logic                      loop_active,
  output logic [$clog2(SDEPTH):0]   stack_level
);
  localparam int SW = $clog2(SDEPTH);
  typedef enum logic {IDLE, ACTIVE} st_t;
  st_t st_q;
  logic [AW-1:0] pc_q, pi_q, pt_q, pc_d, pt_d, next_pc, lp_start_q, lp_end_q;
  logic [CW-1:0] rem_q;
  logic [SW-1:0] sp_q, sp_m1;
  logic [SW:0]   lvl_q;
  logic [AW-1:0] stk_q [SDEPTH];
  logic jmp, hi, push, pop, wrap, start, abort;
  assign rom_addr    = pc_q;
  assign pt          = pt_q;
  assign loop_active = st_q == ACTIVE;
  assign stack_level = lvl_q;
  // priority-resolved next pc, stack and loop events; ext_irq masks all lower-priority side effects
  always_comb begin
    next_pc = pc_q + 1'b1;
    sp_m1   = sp_q - 1'b1;
    jmp     = goto_ja | call_ja | goto_pt | call_pt | ret;
    hi      = ext_irq | icall | jmp | iret;
    push    = !ext_irq && !icall && (call_ja || (!goto_ja && call_pt));
    pop     = !ext_irq && !icall && !(goto_ja || call_ja || goto_pt || call_pt) && ret;
    abort   = st_q == ACTIVE && !ext_irq && !icall && jmp;
    wrap    = st_q == ACTIVE && pc_q == lp_end_q && !shadow && !hi;
    start   = st_q == IDLE && do_start && !ext_irq && do_len != '0 && do_cnt != '0;
    pc_d    = ext_irq               ? AW'(IRQ_VEC)                :
              icall                 ? AW'(ICALL_VEC)              :
              (goto_ja || call_ja)  ? {pc_q[AW-1:12], i_field}    :
              (goto_pt || call_pt)  ? pt_q                        :
              ret                   ? stk_q[sp_m1]                :
              iret                  ? pi_q                        :
              (wrap && rem_q > CW'(1)) ? lp_start_q               : next_pc;
    pt_d    = pt_load  ? pt_din :
              post_inc ? pt_q + {{(AW-12){i_field[11]}}, i_field} : pt_q;
  end
  // pc, interrupt return address and table pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
      pi_q <= '0;
      pt_q <= '0;
    end else if (cen) begin
      pc_q <= pc_d;
      pt_q <= pt_d;
      if (ext_irq) pi_q <= pc_q;
      else if (icall) pi_q <= next_pc;
    end
  end
  // return stack storage; contents need no reset
  always_ff @(posedge clk) begin
    if (cen && push) stk_q[sp_q] <= next_pc;
  end
  // circular stack pointer and saturating occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q  <= '0;
      lvl_q <= '0;
`ifdef JTDSP16_SEQ_ERR_EN
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
`endif
    end else if (cen) begin
      if (push) begin
        sp_q  <= sp_q + 1'b1;
        lvl_q <= lvl_q == (SW+1)'(SDEPTH) ? lvl_q : lvl_q + 1'b1;
      end else if (pop) begin
        sp_q  <= sp_m1;
        lvl_q <= lvl_q == '0 ? lvl_q : lvl_q - 1'b1;
      end
`ifdef JTDSP16_SEQ_ERR_EN
      if (push && lvl_q == (SW+1)'(SDEPTH)) stk_ovf <= 1'b1;
      if (pop && lvl_q == '0) stk_unf <= 1'b1;
`endif
    end
  end
  // do-loop FSM: latch bounds on start, count wraps, drop out on last pass or abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= IDLE;
      lp_start_q <= '0;
      lp_end_q   <= '0;
      rem_q      <= '0;
`ifdef JTDSP16_SEQ_ERR_EN
      loop_abort <= 1'b0;
`endif
    end else if (cen) begin
      if (st_q == IDLE) begin
        if (start) begin
          st_q       <= ACTIVE;
          lp_start_q <= next_pc;
          lp_end_q   <= pc_q + AW'(do_len);
          rem_q      <= do_cnt;
        end
      end else if (abort) begin
        st_q <= IDLE;
      end else if (wrap) begin
        if (rem_q > CW'(1)) rem_q <= rem_q - 1'b1;
        else st_q <= IDLE;
      end
`ifdef JTDSP16_SEQ_ERR_EN
      if (abort) loop_abort <= 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_jtdsp16_seq.sv
// tb_jtdsp16_seq: table-driven scoreboard bench for the JTDSP16 program sequencer
module tb_jtdsp16_seq;
  localparam int C = 1, EI = 2, IC = 4, GJ = 8, GP = 16, CJ = 32, CP = 64, RT = 128;
  localparam int IR = 256, SH = 512, DS = 1024, PL = 2048, PI = 4096;
  typedef struct {
    logic [12:0] ctl;
    logic [11:0] ifld;
    logic [3:0]  len;
    logic [6:0]  cnt;
    logic [15:0] ptd;
    logic [15:0] e_pc;
    logic [2:0]  e_lvl;
    logic        e_la;
    logic [15:0] e_pt;
  } vec_t;
  vec_t tbl[$];
  vec_t exp_q[$];
  int nvec = 0, nerr = 0;
  logic clk = 0, rst_n = 0;
  logic cen = 0, goto_ja = 0, goto_pt = 0, call_ja = 0, call_pt = 0, ret = 0, iret = 0;
  logic icall = 0, ext_irq = 0, shadow = 0, post_inc = 0, pt_load = 0, do_start = 0;
  logic [15:0] pt_din = '0;
  logic [3:0]  do_len = '0;
  logic [6:0]  do_cnt = '0;
  logic [11:0] i_field = '0;
  logic [15:0] rom_addr, pt;
  logic        loop_active;
  logic [2:0]  stack_level;
`ifdef JTDSP16_SEQ_ERR_EN
  logic stk_ovf, stk_unf, loop_abort;
`endif
  always #5 clk = ~clk;
  jtdsp16_seq dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .goto_ja(goto_ja), .goto_pt(goto_pt),
    .call_ja(call_ja), .call_pt(call_pt), .ret(ret), .iret(iret), .icall(icall),
    .ext_irq(ext_irq), .shadow(shadow), .post_inc(post_inc), .pt_load(pt_load),
    .pt_din(pt_din), .do_start(do_start), .do_len(do_len), .do_cnt(do_cnt),
    .i_field(i_field),
`ifdef JTDSP16_SEQ_ERR_EN
    .stk_ovf(stk_ovf), .stk_unf(stk_unf), .loop_abort(loop_abort),
`endif
    .rom_addr(rom_addr), .pt(pt), .loop_active(loop_active), .stack_level(stack_level)
  );
  function automatic void add(input int c, input int f, input int l, input int n, input int d,
                              input int epc, input int lv, input int la, input int ept);
    vec_t v;
    v.ctl = 13'(c); v.ifld = 12'(f); v.len = 4'(l); v.cnt = 7'(n); v.ptd = 16'(d);
    v.e_pc = 16'(epc); v.e_lvl = 3'(lv); v.e_la = la[0]; v.e_pt = 16'(ept);
    tbl.push_back(v);
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic apply(input int idx, input vec_t v);
    vec_t e;
    @(negedge clk);
    {post_inc, pt_load, do_start, shadow, iret, ret, call_pt, call_ja, goto_pt, goto_ja, icall, ext_irq, cen} = v.ctl;
    i_field = v.ifld; do_len = v.len; do_cnt = v.cnt; pt_din = v.ptd;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    nvec++;
    if (rom_addr !== e.e_pc || pt !== e.e_pt || stack_level !== e.e_lvl || loop_active !== e.e_la) begin
      nerr++;
      $display("FAIL vec%0d: rom_addr=%h pt=%h lvl=%0d la=%0d, expected rom_addr=%h pt=%h lvl=%0d la=%0d",
               idx, rom_addr, pt, stack_level, loop_active, e.e_pc, e.e_pt, e.e_lvl, e.e_la);
    end
  endtask
  initial begin
    //   ctl           ifld   len cnt ptd     pc      lvl la pt
    add(C,             0,     0,  0,  0,      1,      0, 0, 0);
    add(C,             0,     0,  0,  0,      2,      0, 0, 0);
    add(C,             0,     0,  0,  0,      3,      0, 0, 0);
    add(C,             0,     0,  0,  0,      4,      0, 0, 0);
    add(C,             0,     0,  0,  0,      5,      0, 0, 0);
    add(0,             0,     0,  0,  0,      5,      0, 0, 0);
    add(CJ,            'h999, 0,  0,  0,      5,      0, 0, 0);
    add(PL,            0,     0,  0,  'h777,  5,      0, 0, 0);
    add(C|PL,          0,     0,  0,  'h1234, 6,      0, 0, 'h1234);
    add(C|GP,          0,     0,  0,  0,      'h1234, 0, 0, 'h1234);
    add(C|CJ,          'h056, 0,  0,  0,      'h1056, 1, 0, 'h1234);
    add(C|RT,          0,     0,  0,  0,      'h1235, 0, 0, 'h1234);
    add(C|PL,          0,     0,  0,  10,     'h1236, 0, 0, 10);
    add(C|GP,          0,     0,  0,  0,      10,     0, 0, 10);
    add(C|CJ,          20,    0,  0,  0,      20,     1, 0, 10);
    add(C|CJ,          30,    0,  0,  0,      30,     2, 0, 10);
    add(C|CJ,          40,    0,  0,  0,      40,     3, 0, 10);
    add(C|CJ,          50,    0,  0,  0,      50,     4, 0, 10);
    add(C|CJ,          60,    0,  0,  0,      60,     4, 0, 10);
    add(C|RT,          0,     0,  0,  0,      51,     3, 0, 10);
    add(C|RT,          0,     0,  0,  0,      41,     2, 0, 10);
    add(C|RT,          0,     0,  0,  0,      31,     1, 0, 10);
    add(C|RT,          0,     0,  0,  0,      21,     0, 0, 10);
    add(C|RT,          0,     0,  0,  0,      51,     0, 0, 10);
    add(C|GJ,          100,   0,  0,  0,      100,    0, 0, 10);
    add(C|DS,          0,     2,  3,  0,      101,    0, 1, 10);
    add(C,             0,     0,  0,  0,      102,    0, 1, 10);
    add(C,             0,     0,  0,  0,      101,    0, 1, 10);
    add(C,             0,     0,  0,  0,      102,    0, 1, 10);
    add(C,             0,     0,  0,  0,      101,    0, 1, 10);
    add(C,             0,     0,  0,  0,      102,    0, 1, 10);
    add(C,             0,     0,  0,  0,      103,    0, 0, 10);
    add(C|GJ,          100,   0,  0,  0,      100,    0, 0, 10);
    add(C|DS,          0,     2,  3,  0,      101,    0, 1, 10);
    add(C|EI,          0,     0,  0,  0,      1,      0, 1, 10);
    add(C|SH,          0,     0,  0,  0,      2,      0, 1, 10);
    add(C|SH|IR,       0,     0,  0,  0,      101,    0, 1, 10);
    add(C,             0,     0,  0,  0,      102,    0, 1, 10);
    add(C,             0,     0,  0,  0,      101,    0, 1, 10);
    add(C,             0,     0,  0,  0,      102,    0, 1, 10);
    add(C,             0,     0,  0,  0,      101,    0, 1, 10);
    add(C,             0,     0,  0,  0,      102,    0, 1, 10);
    add(C,             0,     0,  0,  0,      103,    0, 0, 10);
    add(C|GJ,          100,   0,  0,  0,      100,    0, 0, 10);
    add(C|DS,          0,     2,  3,  0,      101,    0, 1, 10);
    add(C|DS,          0,     5,  5,  0,      102,    0, 1, 10);
    add(C,             0,     0,  0,  0,      101,    0, 1, 10);
    add(C|GJ,          200,   0,  0,  0,      200,    0, 0, 10);
    add(C,             0,     0,  0,  0,      201,    0, 0, 10);
    add(C|IC,          0,     0,  0,  0,      2,      0, 0, 10);
    add(C|IR,          0,     0,  0,  0,      202,    0, 0, 10);
    add(C|PL,          0,     0,  0,  'h200,  203,    0, 0, 'h200);
    add(C|PI,          'hFFE, 0,  0,  0,      204,    0, 0, 'h1FE);
    add(C|GP,          0,     0,  0,  0,      'h1FE,  0, 0, 'h1FE);
    add(C|DS,          0,     2,  0,  0,      'h1FF,  0, 0, 'h1FE);
    add(C|DS,          0,     0,  3,  0,      'h200,  0, 0, 'h1FE);
    add(C,             0,     0,  0,  0,      'h201,  0, 0, 'h1FE);
    add(C|EI|CJ|PL,    5,     0,  0,  'h3333, 1,      0, 0, 'h3333);
    add(C|IR,          0,     0,  0,  0,      'h201,  0, 0, 'h3333);
    add(C|PL|PI,       1,     0,  0,  'h50,   'h202,  0, 0, 'h50);
    add(C|DS,          0,     1,  2,  0,      'h203,  0, 1, 'h50);
    add(C,             0,     0,  0,  0,      'h203,  0, 1, 'h50);
    add(C,             0,     0,  0,  0,      'h204,  0, 0, 'h50);
    add(C|CP,          0,     0,  0,  0,      'h50,   1, 0, 'h50);
    add(C|RT,          0,     0,  0,  0,      'h205,  0, 0, 'h50);
    #12;
    chk("reset_pc", int'(rom_addr), 0);
    chk("reset_pt", int'(pt), 0);
    chk("reset_lvl", int'(stack_level), 0);
    chk("reset_la", int'(loop_active), 0);
    @(negedge clk);
    rst_n = 1;
    foreach (tbl[i]) apply(i, tbl[i]);
`ifdef JTDSP16_SEQ_ERR_EN
    chk("stk_ovf", int'(stk_ovf), 1);
    chk("stk_unf", int'(stk_unf), 1);
    chk("loop_abort", int'(loop_abort), 1);
`endif
    @(negedge clk);
    {post_inc, pt_load, do_start, shadow, iret, ret, call_pt, call_ja, goto_pt, goto_ja, icall, ext_irq, cen} = 13'(C|DS);
    do_len = 4'd3; do_cnt = 7'd4;
    @(posedge clk);
    #1;
    chk("pre_areset_la", int'(loop_active), 1);
    #2;
    rst_n = 0;
    #1;
    chk("areset_pc", int'(rom_addr), 0);
    chk("areset_pt", int'(pt), 0);
    chk("areset_la", int'(loop_active), 0);
`ifdef JTDSP16_SEQ_ERR_EN
    chk("areset_ovf", int'(stk_ovf), 0);
`endif
    @(posedge clk);
    #1;
    chk("held_reset_pc", int'(rom_addr), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/jtdsp16_seq.md
Name: jtdsp16_seq

Overview:
- Parametrised program sequencer (XAAU successor) for the JTDSP16 core.
- Generates the ROM fetch address and handles:
  - sequential flow, direct and table-pointer jumps/calls
  - a hardware return stack of configurable depth
  - interrupt entry/return
  - a zero-overhead "do" loop that repeats a short instruction block K times
- Sits between the instruction decoder and program ROM; all state advances only on cen.

Parameters:
- AW, 16, program address width (≥13).
- SDEPTH, 4, return stack entries (power of two, ≥2).
- CW, 7, do-loop repeat count width.
- NW, 4, do-loop body length width (body 1..2^NW-1 instructions).
- IRQ_VEC, 1, address loaded on ext_irq.
- ICALL_VEC, 2, address loaded on icall.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cen  in  1  clock enable; no state changes when 0
- goto_ja  in  1  jump to {pc[AW-1:12], i_field}
- goto_pt  in  1  jump to pt
- call_ja  in  1  push next_pc, jump to {pc[AW-1:12], i_field}
- call_pt  in  1  push next_pc, jump to pt
- ret  in  1  pop stack into pc
- iret  in  1  pc <= pi
- icall  in  1  software interrupt: pi <= next_pc, pc <= ICALL_VEC
- ext_irq  in  1  hardware interrupt: pi <= pc, pc <= IRQ_VEC
- shadow  in  1  1 while executing an interrupt handler
- post_inc  in  1  pt <= pt + sign-extended i_field
- pt_load  in  1  pt <= pt_din
- pt_din  in  AW  table pointer load value
- do_start  in  1  start do loop
- do_len  in  NW  loop body length
- do_cnt  in  CW  loop repeat count
- i_field  in  12  instruction immediate
- rom_addr  out  AW  fetch address (= pc)
- pt  out  AW  table pointer
- loop_active  out  1  do loop in progress
- stack_level  out  log2(SDEPTH)+1  stack occupancy, 0..SDEPTH

Behaviour:
- Reset (rst_n=0, async):
  - pc, pi, pt = 0; stack pointer = 0; stack_level = 0.
  - Loop FSM = IDLE; loop_active = 0; all error flags = 0.
- next_pc = pc+1, wrapping modulo 2^AW.
- Adding a constant offset to pc: arithmetic is unsigned with wrap.
- PC priority on each cen cycle, highest first:
  1. ext_irq
  2. icall
  3. goto_ja / call_ja
  4. goto_pt / call_pt
  5. ret
  6. iret
  7. loop wrap
  8. next_pc
- Decoder guarantees at most one of items 2-6 per cycle; the bench need not check combinations among them.
- Lower-priority side effects are suppressed when ext_irq is high, including pushes, pops and loop start.
- pt updates are independent of PC priority:
  - pt_load has priority over post_inc.
  - pt updates still occur during ext_irq.
- Return stack (circular, SDEPTH entries):
  - Push on call writes next_pc.
  - Push when full overwrites the oldest entry; stack_level stays at SDEPTH.
  - Pop when empty returns the entry at the wrapped pointer; stack_level stays 0.
- Do-loop FSM, states IDLE and ACTIVE:
  - IDLE → ACTIVE on do_start with do_len≠0 and do_cnt≠0. Latches:
    - loop_start = next_pc
    - loop_end = pc + do_len
    - remaining = do_cnt
  - do_start with do_len=0 or do_cnt=0 is a no-op: pc advances and the FSM stays IDLE.
  - In ACTIVE, when pc==loop_end and shadow=0 and no higher-priority event:
    - if remaining>1: pc <= loop_start, remaining decrements;
    - else pc <= next_pc, state → IDLE.
  - Interrupts inside a loop: ext_irq/icall freeze loop state; the compare is disabled while shadow=1, and iret resumes the loop.
  - goto_ja, goto_pt, call_ja, call_pt or ret issued in ACTIVE abort the loop (→ IDLE), and the flow change takes effect.
  - do_start while ACTIVE is ignored; nesting is unsupported.
- loop_active = (state==ACTIVE), registered.
- stack_level is registered.

Optional Feature:
- Macro: JTDSP16_SEQ_ERR_EN.
- When defined, adds outputs stk_ovf, stk_unf and loop_abort (1 bit each):
  - stk_ovf is set by a push when full.
  - stk_unf is set by a pop when empty.
  - loop_abort is set when a flow change aborts an ACTIVE loop.
  - All three are sticky until reset.
- When undefined, these ports and their logic are absent; stack/loop behaviour is unchanged.

Test Plan:
- Reset then 5 cen cycles → rom_addr 0,1,2,3,4. Hold cen=0 for 3 cycles → rom_addr stays 5.
- At pc=0x1234, call_ja with i_field=0x056 → pc=0x1056, stack_level=1. Then ret → pc=0x1235, stack_level=0.
- SDEPTH=4: five nested call_ja from pc=10,20,30,40,50, then four ret → pc 51,41,31,21. stk_ovf=1 when the feature is enabled.
- At pc=100, do_start with do_len=2, do_cnt=3 → rom_addr sequence 101,102,101,102,101,102,103; loop_active falls after the last 102.
- During that loop at pc=101, ext_irq → pc=IRQ_VEC, pi=101. Handler iret → resumes at 101; total body iterations remain 3.
- pt_load with 0x0200, then post_inc with i_field=0xFFE → pt=0x01FE. goto_pt → pc=0x01FE. do_start with do_cnt=0 → no loop, pc+1.
